mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_LO, default 400, lowest legal data address (ROM base).
REQ-002 SHALL have parameter RAM_LO, default 8500, lowest RAM address; range ADDR_LO..RAM_LO-1 is read-only.
REQ-003 SHALL have parameter ADDR_HI, default 138100, first illegal address above RAM.
REQ-004 SHALL have ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low reset.
- cpu_req, cpu_we  in  1  CPU access request, write enable.
- cpu_addr, cpu_wd  in  32  CPU byte address, write data.
- cpu_rd  out  32  CPU read data, registered.
- cpu_ack  out  1  one-cycle completion pulse to CPU.
- cpu_stall  out  1  cpu_req & ~cpu_ack, pipeline freeze.
- dma_req, dma_we  in  1  DMA access request, write enable.
- dma_addr, dma_wd  in  32  DMA address, write data.
- dma_rd  out  32  DMA read data, registered.
- dma_ack  out  1  one-cycle completion pulse to DMA.
- mem_we  out  1  write enable to memory controller.
- mem_addr, mem_wd  out  32  address, write data to memory controller.
- mem_rd  in  32  read data from memory controller, valid in the cycle after mem_addr is presented.
- err  out  1  one-cycle pulse: illegal address or write to read-only region.

Function
REQ-005 SHALL implement FSM states IDLE, ACCESS, RESPOND; IDLE->ACCESS when any req is high; ACCESS->RESPOND unconditionally; RESPOND->IDLE unconditionally.
REQ-006 SHALL select the owner in IDLE only; owner SHALL be latched and held through ACCESS and RESPOND.
REQ-007 SHALL require each requester to hold req, we, addr and wd stable from assertion until its ack; the owner's inputs are used during ACCESS.
REQ-008 SHALL drive mem_addr/mem_wd from the owner during ACCESS, and 0 in all other states.
REQ-009 SHALL assert mem_we for exactly the one ACCESS cycle when the owner's we=1 and the address is in RAM_LO..ADDR_HI-1.
REQ-010 SHALL, at the ACCESS->RESPOND edge, register the owner's rd as mem_rd for legal reads, 0 for illegal reads, and leave it unchanged for writes; the non-owner's rd SHALL be unchanged.
REQ-011 SHALL assert the owner's ack for exactly the RESPOND cycle; latency from req sampled high in IDLE to ack is 2 cycles, throughput one access per 3 cycles.
REQ-012 SHALL treat an address < ADDR_LO or >= ADDR_HI as illegal: no mem_we, err=1 in RESPOND, ack still issued.
REQ-013 SHALL treat a write to ADDR_LO..RAM_LO-1 as a read-only violation: mem_we=0, err=1 in RESPOND, ack issued.
REQ-014 SHALL, when a requester drops req before ack, still complete the latched transaction; a later ack is ignored by that requester.
REQ-015 SHALL evaluate a req held high in RESPOND only on return to IDLE, with no back-to-back re-grant inside RESPOND.

Reset
REQ-016 SHALL, with reset=0 at a rising edge, enter IDLE and clear cpu_rd, dma_rd, acks, err, mem_we, mem_addr, mem_wd and last-grant (last-grant = DMA).
REQ-017 SHALL abort an in-flight transaction on reset mid-ACCESS/RESPOND: no ack, no err, and no mem_we in the cycle after reset.

Configuration
REQ-018 SHALL, with macro MEM_ARBITER_ROUND_ROBIN_EN defined, grant the requester not last granted when both request in IDLE, then update last-grant.
REQ-019 SHALL, without MEM_ARBITER_ROUND_ROBIN_EN, always grant CPU when both request; DMA is granted only when cpu_req=0 in IDLE.

Verification
REQ-020 CPU read addr 8500 with memory holding 0xDEADBEEF -> mem_addr=8500 in cycle 1, cpu_ack and cpu_rd=0xDEADBEEF in cycle 2, err=0.
REQ-021 DMA write addr 8504 data 0x12345678 -> mem_we=1 for one cycle with mem_addr=8504 and mem_wd=0x12345678; dma_ack one cycle later.
REQ-022 CPU write addr 400 -> mem_we stays 0; err=1 and cpu_ack=1 in same cycle. CPU read addr 138100 -> cpu_rd=0, err=1.
REQ-023 Both req held high for 6 accesses with MEM_ARBITER_ROUND_ROBIN_EN -> grant order CPU,DMA,CPU,DMA,CPU,DMA. Without the macro -> CPU six times, dma_ack never.
REQ-024 reset=0 during ACCESS of a CPU write -> next cycle IDLE, mem_we=0, cpu_ack=0, err=0; cpu_rd=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (CPU, DMA) arbiter in front of a single memory
// controller. Each access is a fixed IDLE -> ACCESS -> RESPOND sequence; the
// owner is chosen in IDLE and latched for the whole access. Addresses are
// classified as illegal (< ADDR_LO or >= ADDR_HI), read-only ROM
// (ADDR_LO..RAM_LO-1) or RAM (RAM_LO..ADDR_HI-1).
//
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   cpu_req/we/addr/wd    CPU request, held stable until cpu_ack
//   cpu_rd, cpu_ack       CPU read data (registered), completion pulse
//   cpu_stall             cpu_req & ~cpu_ack (combinational freeze)
//   dma_req/we/addr/wd    DMA request, held stable until dma_ack
//   dma_rd, dma_ack       DMA read data (registered), completion pulse
//   mem_we/addr/wd        memory controller command, valid in ACCESS only
//   mem_rd                memory read data, sampled at the end of ACCESS
//   err                   pulse in RESPOND for illegal/read-only accesses
//
// Configuration:
//   MEM_ARBITER_ROUND_ROBIN_EN  defined: alternate grants when both request
//                               undefined: CPU has fixed priority
module mem_arbiter #(
   parameter int unsigned ADDR_LO = 400,
   parameter int unsigned RAM_LO  = 8500,
   parameter int unsigned ADDR_HI = 138100
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wd,
   output logic [31:0] cpu_rd,
   output logic        cpu_ack,
   output logic        cpu_stall,
   input  logic        dma_req,
   input  logic        dma_we,
   input  logic [31:0] dma_addr,
   input  logic [31:0] dma_wd,
   output logic [31:0] dma_rd,
   output logic        dma_ack,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd,
   output logic        err
);

   localparam int unsigned AW = 32;
   localparam logic [AW-1:0] LO_A  = AW'(ADDR_LO);
   localparam logic [AW-1:0] RAM_A = AW'(RAM_LO);
   localparam logic [AW-1:0] HI_A  = AW'(ADDR_HI);

   typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

   state_t        state;
   logic          own_dma;
   logic          own_we;
   logic          own_bad;
   logic          own_ro;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
   logic          last_dma;
`endif

   logic          grant_dma_c;
   logic          sel_we_c;
   logic [AW-1:0] sel_addr_c;
   logic [AW-1:0] sel_wd_c;
   logic          sel_bad_c;
   logic          sel_ro_c;
   logic [AW-1:0] rd_c;

   assign cpu_stall = cpu_req & ~cpu_ack;

   // Grant decision and classification of the candidate owner's request.
   always_comb begin
      grant_dma_c = 1'b0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      if (cpu_req && dma_req) grant_dma_c = ~last_dma;
      else                    grant_dma_c = dma_req;
`else
      grant_dma_c = dma_req & ~cpu_req;
`endif
      sel_we_c   = grant_dma_c ? dma_we   : cpu_we;
      sel_addr_c = grant_dma_c ? dma_addr : cpu_addr;
      sel_wd_c   = grant_dma_c ? dma_wd   : cpu_wd;
      sel_bad_c  = (sel_addr_c < LO_A) || (sel_addr_c >= HI_A);
      sel_ro_c   = sel_we_c && !sel_bad_c && (sel_addr_c < RAM_A);
      // Illegal reads return zero instead of whatever the controller drives.
      rd_c       = own_bad ? '0 : mem_rd;
   end

   // Access sequencer; command and response outputs are pulses by default.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         own_dma  <= 1'b0;
         own_we   <= 1'b0;
         own_bad  <= 1'b0;
         own_ro   <= 1'b0;
         cpu_rd   <= '0;
         dma_rd   <= '0;
         cpu_ack  <= 1'b0;
         dma_ack  <= 1'b0;
         err      <= 1'b0;
         mem_we   <= 1'b0;
         mem_addr <= '0;
         mem_wd   <= '0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
         last_dma <= 1'b1;
`endif
      end else begin
         cpu_ack  <= 1'b0;
         dma_ack  <= 1'b0;
         err      <= 1'b0;
         mem_we   <= 1'b0;
         mem_addr <= '0;
         mem_wd   <= '0;
         case (state)
            IDLE: begin
               if (cpu_req || dma_req) begin
                  state    <= ACCESS;
                  own_dma  <= grant_dma_c;
                  own_we   <= sel_we_c;
                  own_bad  <= sel_bad_c;
                  own_ro   <= sel_ro_c;
                  mem_addr <= sel_addr_c;
                  mem_wd   <= sel_wd_c;
                  mem_we   <= sel_we_c & ~sel_bad_c & ~sel_ro_c;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
                  last_dma <= grant_dma_c;
`endif
               end
            end
            ACCESS: begin
               state <= RESPOND;
               err   <= own_bad | own_ro;
               if (own_dma) dma_ack <= 1'b1;
               else         cpu_ack <= 1'b1;
               // Writes leave the owner's read data untouched.
               if (!own_we) begin
                  if (own_dma) dma_rd <= rd_c;
                  else         cpu_rd <= rd_c;
               end
            end
            RESPOND: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
